uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Arbitrates a single UART transmitter between two byte-stream requesters: requester 0 is the image pixel streamer, requester 1 is the status/telemetry source. Each grant covers a whole packet, so a multi-byte packet is never interleaved with another source's bytes. The block drives the UART core's tx_data/txEn/txStart interface and waits for txDone between bytes. A watchdog recovers from a stalled UART or an abandoned packet.

## Interface
Parameters:
- TX_TIMEOUT, 1_000_000: the watchdog limit, in clk cycles. It bounds both the wait for txDone and the wait for a locked owner's next byte. Legal range is 2 to 2^24-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte on req0_data.
- req0_data  in  8  requester 0 byte; must be held stable while req0_valid=1 and req0_ready=0.
- req0_last  in  1  the byte on req0_data is the last byte of its packet; qualified by req0_valid.
- req0_ready  out  1  one-cycle pulse; the byte is consumed at the end of this cycle.
- req1_valid / req1_data / req1_last / req1_ready  same as requester 0, for requester 1.
- tx_data  out  8  byte to the UART core.
- txEn  out  1  UART transmit enable.
- txStart  out  1  UART start request; held high until txDone.
- txDone  in  1  UART byte-complete pulse.
- txBusy  in  1  UART is shifting a byte.
- grant  out  2  one-hot current packet owner; 00 when no packet is owned.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  synchronous clear of timeout_err.

## Operation
States:
- IDLE
  - Condition to leave: txBusy=0 and at least one reqN_valid=1.
  - Selects the owner per the arbitration policy (see Configuration).
  - Registers grant and goes to LOAD.
- LOCK
  - Only the current owner is considered; the other requester waits.
  - On owner valid=1 with txBusy=0, goes to LOAD.
- LOAD
  - reqN_ready=1 for the owner only.
  - At the end of the cycle: tx_data <= reqN_data, last_q <= reqN_last, watchdog counter cleared.
  - Goes to START.
- START
  - txEn=1 and txStart=1.
  - On txDone=1: goes to IDLE if last_q=1 (grant cleared), otherwise to LOCK.
- Watchdog
  - A 24-bit counter increments each cycle in START and in LOCK, and clears on every state change.
  - When the counter reaches TX_TIMEOUT-1 in either state, the next state is IDLE.
  - On that transition: grant <= 00, timeout_err <= 1, txEn/txStart <= 0, and the byte in flight is dropped.
- err_clr=1 clears timeout_err. If err_clr and a timeout occur in the same cycle, the timeout wins (flag ends at 1).
- A requester whose valid drops while it does not own the UART is not granted; there is no retained request.
- A non-owner's ready is never asserted.

## Timing
- Reset values: req0_ready=0, req1_ready=0, tx_data=8'h00, txEn=0, txStart=0, grant=2'b00, timeout_err=0, state=IDLE, watchdog counter=0, last_q=0, RR pointer=0.
- Reset is asynchronous. Asserting it mid-byte drops txEn/txStart immediately, and the packet is abandoned.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from IDLE:
  - cycle n: valid seen with txBusy=0.
  - cycle n+1: grant and ready high (LOAD).
  - cycle n+2: tx_data, txEn and txStart valid.
- txDone observed in cycle m gives txEn=txStart=0 in cycle m+1.
- The next byte can have its ready no earlier than m+2, even if valid is already high and txBusy is low at m+1.
- A txDone outside START is ignored.
- txBusy=1 in IDLE or LOCK stalls the request: no ready, no state change. Watchdog counting continues in LOCK.
- A single-byte packet (last=1 on the first byte) returns to IDLE after its txDone. Minimum per-byte cost is 3 cycles plus the UART frame time.

## Configuration
- UART_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit priority pointer selects which requester wins when both are valid in IDLE.
  - The pointer flips to the non-winner on every packet release, whether normal (last) or by timeout.
  - Reset pointer = 0, so requester 0 wins first.
- Undefined:
  - Fixed priority; requester 0 always wins a simultaneous request in IDLE.
  - No pointer register is present.

## Test plan
- Single byte: req1_valid=1, data=8'hA5, last=1.
  - Expect: req1_ready pulse at n+1, tx_data=A5 and txStart=1 from n+2, grant=2'b10 until txDone, then grant=00.
- Packet lock: req0 sends the 3-byte packet 01,02,03 (last on 03) while req1 is continuously valid with data 8'hFF.
  - Expect: the UART sees 01,02,03 before FF, and req1_ready stays 0 until req0's packet is released.
- Simultaneous requests: both requesters valid from IDLE, two single-byte packets each.
  - With UART_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
  - Without it: order 0,0,1,1.
- UART stall: txDone is never asserted, with TX_TIMEOUT=16.
  - Expect: txStart high for exactly 16 cycles, then txStart=0, grant=00, timeout_err=1.
  - Then err_clr=1 gives timeout_err=0 on the next cycle.
- Abandoned packet: req0 sends 2 bytes with last=0, then drops valid; TX_TIMEOUT=16.
  - Expect: LOCK times out after 16 cycles, timeout_err=1, and a pending req1 byte is then granted.
- Reset mid-transfer: assert rst_n=0 while txStart=1.
  - Expect: txStart, txEn, grant and ready all 0 without waiting for a clk edge.
  - After release, a new req0 byte transmits normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte-stream requesters
//   (0 = image pixel streamer, 1 = status/telemetry). A grant covers a whole
//   packet, so one source's bytes are never interleaved with the other's.
//   A watchdog recovers from a UART that never reports txDone and from an
//   owner that stops sending in the middle of a packet.
//
// Parameters
//   TX_TIMEOUT   watchdog limit in clk cycles (2 .. 2^24-1)
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/data/last        requester N byte offer (N = 0,1)
//   reqN_ready                  one-cycle pulse, byte consumed this cycle
//   tx_data, txEn, txStart      UART core transmit interface
//   txDone, txBusy              UART core status
//   grant                       one-hot packet owner, 00 when free
//   timeout_err, err_clr        sticky watchdog flag and its clear
//
// Build option
//   UART_ARB_ROUND_ROBIN_EN     defined: round-robin between simultaneous
//                               requests; undefined: requester 0 has priority
//
// state | meaning
// IDLE  | no owner; pick one when a request is seen and the UART is free
// LOCK  | packet owner holds the UART between bytes
// LOAD  | owner's ready pulse; byte captured at the end of the cycle
// START | byte handed to the UART, waiting for txDone

module uart_tx_arbiter #(
  parameter int unsigned TX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       txEn,
  output logic       txStart,
  input  logic       txDone,
  input  logic       txBusy,
  output logic [1:0] grant,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam logic [23:0] WD_LAST = 24'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_LOAD, S_START} state_t;

  state_t      r_state;
  logic [23:0] r_wd;
  logic        r_last;
  logic [1:0]  r_grant;
  logic        r_rdy0;
  logic        r_rdy1;
  logic [7:0]  r_data;
  logic        r_txen;
  logic        r_txstart;
  logic        r_err;

  logic        w_own1;
  logic        w_own_valid;
  logic [7:0]  w_own_data;
  logic        w_own_last;
  logic        w_own_go;
  logic        w_wd_exp;
  logic        w_timeout;
  logic        w_pick1;

  // grant is one-hot, so bit 1 alone identifies the owner
  assign w_own1      = r_grant[1];
  assign w_own_valid = w_own1 ? req1_valid : req0_valid;
  assign w_own_data  = w_own1 ? req1_data  : req0_data;
  assign w_own_last  = w_own1 ? req1_last  : req0_last;
  assign w_own_go    = w_own_valid & ~txBusy;
  assign w_wd_exp    = (r_wd == WD_LAST);
  // an owner's next byte in LOCK and a txDone in START both beat the watchdog
  assign w_timeout   = w_wd_exp & (((r_state == S_START) & ~txDone) |
                                   ((r_state == S_LOCK)  & ~w_own_go));

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic r_rr;
  logic w_release;

  assign w_release = w_timeout | ((r_state == S_START) & txDone & r_last);
  assign w_pick1   = req1_valid & (~req0_valid | r_rr);

  // after any release the pointer favours whoever did not just own the UART
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (w_release) begin
      r_rr <= ~w_own1;
    end
  end
`else
  assign w_pick1 = req1_valid & ~req0_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wd      <= '0;
      r_last    <= 1'b0;
      r_grant   <= 2'b00;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
      r_data    <= 8'h00;
      r_txen    <= 1'b0;
      r_txstart <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdy0 <= 1'b0;
      r_rdy1 <= 1'b0;
      // a timeout later in this block overrides the clear
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!txBusy && (req0_valid || req1_valid)) begin
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_rdy0  <= ~w_pick1;
            r_rdy1  <= w_pick1;
            r_state <= S_LOAD;
          end
        end
        S_LOCK: begin
          if (w_own_go) begin
            r_rdy0  <= ~w_own1;
            r_rdy1  <= w_own1;
            r_wd    <= '0;
            r_state <= S_LOAD;
          end else if (w_timeout) begin
            r_grant <= 2'b00;
            r_err   <= 1'b1;
            r_wd    <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 24'd1;
          end
        end
        S_LOAD: begin
          r_data    <= w_own_data;
          r_last    <= w_own_last;
          r_wd      <= '0;
          r_txen    <= 1'b1;
          r_txstart <= 1'b1;
          r_state   <= S_START;
        end
        S_START: begin
          if (txDone) begin
            r_txen    <= 1'b0;
            r_txstart <= 1'b0;
            r_wd      <= '0;
            if (r_last) begin
              r_grant <= 2'b00;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_LOCK;
            end
          end else if (w_timeout) begin
            // the byte in flight is abandoned
            r_txen    <= 1'b0;
            r_txstart <= 1'b0;
            r_grant   <= 2'b00;
            r_err     <= 1'b1;
            r_wd      <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_wd <= r_wd + 24'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready  = r_rdy0;
  assign req1_ready  = r_rdy1;
  assign tx_data     = r_data;
  assign txEn        = r_txen;
  assign txStart     = r_txstart;
  assign grant       = r_grant;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

`ifdef UART_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
  localparam logic [1:0] EXP_SECOND = 2'b10;
`else
  localparam bit RR_EN = 1'b0;
  localparam logic [1:0] EXP_SECOND = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_last = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       txEn, txStart;
  logic       txDone = 1'b0;
  logic       txBusy = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // requester byte queues: bit 8 = last
  logic [8:0] q0[$], q1[$];
  logic [8:0] s0[$], s1[$];
  // UART-side log and model expectation: {grant, byte}
  logic [9:0] log_q[$], exp_q[$];
  logic       m_ptr = 1'b0;
  bit         uart_en = 1'b1;
  int         dmin = 0, dmax = 0;
  int         bad_rdy0 = 0, bad_rdy1 = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .txEn(txEn), .txStart(txStart), .txDone(txDone), .txBusy(txBusy),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // requester 0: present queue head, pop once the ready cycle has passed
  initial begin : drv0
    bit c0;
    logic [8:0] t;
    c0 = 1'b0;
    forever begin
      @(negedge clk);
      if (c0) t = q0.pop_front();
      c0 = req0_ready;
      if (req0_ready && grant !== 2'b01) bad_rdy0++;
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_data = q0[0][7:0]; req0_last = q0[0][8];
      end else begin
        req0_valid = 1'b0;
      end
    end
  end

  initial begin : drv1
    bit c1;
    logic [8:0] t;
    c1 = 1'b0;
    forever begin
      @(negedge clk);
      if (c1) t = q1.pop_front();
      c1 = req1_ready;
      if (req1_ready && grant !== 2'b10) bad_rdy1++;
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_data = q1[0][7:0]; req1_last = q1[0][8];
      end else begin
        req1_valid = 1'b0;
      end
    end
  end

  // UART core: log each byte when txStart rises, answer txDone after a delay
  initial begin : uart
    bit seen;
    int cnt;
    seen = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      txDone = 1'b0;
      if (txStart && !seen) begin
        seen = 1'b1;
        log_q.push_back({grant, tx_data});
        cnt = $urandom_range(dmax, dmin);
      end else if (!txStart) begin
        seen = 1'b0;
      end
      if (seen && uart_en) begin
        if (cnt == 0) txDone = 1'b1;
        else cnt--;
      end
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  // Packet-level model: while both sources have packets the policy picks the
  // owner, who then sends a complete packet; the pointer moves to the loser.
  function automatic void predict();
    logic [8:0] a[$], b[$];
    logic [8:0] e;
    logic pick;
    a = s0;
    b = s1;
    exp_q.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if (a.size() > 0 && b.size() > 0) pick = RR_EN ? m_ptr : 1'b0;
      else pick = (a.size() == 0);
      do begin
        e = pick ? b.pop_front() : a.pop_front();
        exp_q.push_back({(pick ? 2'b10 : 2'b01), e[7:0]});
      end while (!e[8] && (pick ? b.size() : a.size()) > 0);
      m_ptr = ~pick;
    end
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scn();
    predict();
    log_q.delete();
    bad_rdy0 = 0;
    bad_rdy1 = 0;
    go();
    foreach (s0[i]) q0.push_back(s0[i]);
    foreach (s1[i]) q1.push_back(s1[i]);
  endtask

  task automatic finish_scn(input string tag);
    int k = 0;
    while ((log_q.size() < exp_q.size() || grant !== 2'b00 || txStart !== 1'b0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_wait"}, 32'(k < 3000), 32'd1);
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    check({tag, "_nonowner_ready"}, 32'(bad_rdy0 + bad_rdy1), 32'd0);
  endtask

  task automatic wait_sig_high(input string tag, input int which);
    int k = 0;
    while (k < 200 && !((which == 0) ? (txStart === 1'b1) : (grant === 2'b01))) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 200), 32'd1);
  endtask

  initial begin : main
    int n;
    int k;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'h00);
    check("rst_tx", 32'({txEn, txStart}), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    go();
    rst_n = 1'b1;

    // single byte from requester 1, latency checks
    dmin = 3; dmax = 3;
    s0.delete(); s1.delete();
    s1.push_back({1'b1, 8'hA5});
    start_scn();
    @(negedge clk);
    check("sb_n_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("sb_n1_ready", 32'(req1_ready), 32'd1);
    check("sb_n1_grant", 32'(grant), 32'b10);
    check("sb_n1_txstart", 32'(txStart), 32'd0);
    @(negedge clk);
    check("sb_n2_txdata", 32'(tx_data), 32'hA5);
    check("sb_n2_tx", 32'({txEn, txStart}), 32'b11);
    check("sb_n2_ready", 32'(req1_ready), 32'd0);
    check("sb_n2_grant", 32'(grant), 32'b10);
    finish_scn("single");

    // packet lock: 01,02,03 from requester 0 with requester 1 waiting on FF
    dmin = 0; dmax = 4;
    s0.delete(); s1.delete();
    s0.push_back({1'b0, 8'h01}); s0.push_back({1'b0, 8'h02}); s0.push_back({1'b1, 8'h03});
    s1.push_back({1'b1, 8'hFF});
    start_scn();
    finish_scn("lock");

    // simultaneous requests, two single-byte packets each
    s0.delete(); s1.delete();
    s0.push_back({1'b1, 8'h10}); s0.push_back({1'b1, 8'h11});
    s1.push_back({1'b1, 8'h20}); s1.push_back({1'b1, 8'h21});
    start_scn();
    finish_scn("simul");
    if (log_q.size() > 1) check("simul_2nd_grant", 32'(log_q[1][9:8]), 32'(EXP_SECOND));

    // txBusy holds off a request in IDLE
    txBusy = 1'b1;
    s0.delete(); s1.delete();
    s0.push_back({1'b1, 8'h5A});
    start_scn();
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (req0_ready === 1'b1 || grant !== 2'b00) n++;
    end
    check("busy_hold", 32'(n), 32'd0);
    txBusy = 1'b0;
    finish_scn("busy");

    // randomized packet mixes
    for (int r = 0; r < 5; r++) begin
      dmin = 0; dmax = 8;
      s0.delete(); s1.delete();
      for (int p = 0; p < 2; p++) begin
        int len0, len1, np0, np1;
        np0 = $urandom_range(1, 0); np1 = $urandom_range(1, 0);
        len0 = $urandom_range(4, 1); len1 = $urandom_range(4, 1);
        for (int j = 0; j < len0 && np0 != 0; j++) s0.push_back({(j == len0 - 1), 8'($urandom)});
        for (int j = 0; j < len1 && np1 != 0; j++) s1.push_back({(j == len1 - 1), 8'($urandom)});
      end
      start_scn();
      finish_scn($sformatf("rnd%0d", r));
    end

    // UART stall: txDone never arrives
    uart_en = 1'b0;
    log_q.delete();
    go();
    q0.push_back({1'b1, 8'h77});
    wait_sig_high("stall_start_seen", 0);
    n = 0;
    while (txStart === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("stall_len", 32'(n), 32'd16);
    check("stall_tx", 32'({txEn, txStart}), 32'd0);
    check("stall_grant", 32'(grant), 32'd0);
    check("stall_err", 32'(timeout_err), 32'd1);
    repeat (3) @(negedge clk);
    check("stall_err_sticky", 32'(timeout_err), 32'd1);
    go();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("stall_err_clr", 32'(timeout_err), 32'd0);
    uart_en = 1'b1;

    // abandoned packet: two non-last bytes, then silence; requester 1 waits
    dmin = 2; dmax = 2;
    log_q.delete();
    bad_rdy0 = 0; bad_rdy1 = 0;
    go();
    q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32});
    wait_sig_high("abandon_grant_seen", 1);
    go();
    q1.push_back({1'b1, 8'h41});
    k = 0;
    while (!(log_q.size() >= 2 && txStart === 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abandon_2bytes", 32'(k < 200), 32'd1);
    n = 0;
    while (grant === 2'b01 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("abandon_lock_len", 32'(n), 32'd16);
    check("abandon_err", 32'(timeout_err), 32'd1);
    check("abandon_grant", 32'(grant), 32'd0);
    k = 0;
    while ((log_q.size() < 3 || grant !== 2'b00 || txStart !== 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abandon_req1_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() > 2) check("abandon_req1_byte", 32'(log_q[2]), 32'({2'b10, 8'h41}));
    check("abandon_nonowner_ready", 32'(bad_rdy0 + bad_rdy1), 32'd0);
    go();
    err_clr = 1'b1;
    go();
    err_clr = 1'b0;

    // reset in the middle of a byte
    uart_en = 1'b0;
    go();
    q0.push_back({1'b1, 8'h55});
    wait_sig_high("rst_mid_start_seen", 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'({txEn, txStart}), 32'd0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_ready", 32'({req0_ready, req1_ready}), 32'd0);
    go();
    rst_n = 1'b1;
    uart_en = 1'b1;
    m_ptr = 1'b0;
    dmin = 1; dmax = 3;
    s0.delete(); s1.delete();
    s0.push_back({1'b1, 8'h66});
    start_scn();
    finish_scn("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
